sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 216 +++++++++++++++++++++
 tb/tb_sync_fifo_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with an arbitrary (non power-of-two) depth, occupancy flags,
// a one-cycle registered read port, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 46,
    parameter int AF_TH      = 44,
    parameter int AE_TH      = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  r_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic [PTR_W-1:0]      wptr,
    output logic [PTR_W-1:0]      rptr,
    output logic                  overflow,
    output logic                  underflow
);

    generate
        if (!(DEPTH >= 2 && AE_TH >= 1 && AE_TH < AF_TH && AF_TH <= DEPTH)) begin : g_bad_cfg
            $error("sync_fifo_param: need DEPTH >= 2 and 1 <= AE_TH < AF_TH <= DEPTH");
        end
    endgenerate

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_TH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  r_valid_r;
    logic [PTR_W-1:0]      wptr_r;
    logic [PTR_W-1:0]      rptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  overflow_r;
    logic                  underflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  almost_full_s;
    logic                  almost_empty_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic [PTR_W-1:0]      wptr_nxt_s;
    logic [PTR_W-1:0]      rptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  overflow_nxt_s;
    logic                  underflow_nxt_s;

    // Wrapping increment: the last index folds back to 0 so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Occupancy flags decoded straight from the count register.
    always_comb begin
        full_s         = (count_r == CNT_FULL);
        empty_s        = (count_r == {CNT_W{1'b0}});
        almost_full_s  = (count_r >= CNT_AF);
        almost_empty_s = (count_r <= CNT_AE);
    end

    // Accept decisions; flush suppresses both requests and any error they would raise.
    always_comb begin
        rd_acc_s  = !flush && r_en && !empty_s;
        wr_acc_s  = !flush && w_en && (!full_s || rd_acc_s);
        ovf_set_s = !flush && w_en && !wr_acc_s;
        unf_set_s = !flush && r_en && empty_s;
    end

    // Next pointer and occupancy values.
    always_comb begin
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;
        if (flush) begin
            wptr_nxt_s  = {PTR_W{1'b0}};
            rptr_nxt_s  = {PTR_W{1'b0}};
            count_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_nxt_s = ptr_inc(wptr_r);
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (rd_acc_s) begin
                rptr_nxt_s = ptr_inc(rptr_r);
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Sticky error flags: a new event outranks a clear in the same cycle.
    always_comb begin
        if (ovf_set_s) begin
            overflow_nxt_s = 1'b1;
        end else if (clr_err) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (unf_set_s) begin
            underflow_nxt_s = 1'b1;
        end else if (clr_err) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Control state and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r      <= {PTR_W{1'b0}};
            rptr_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            data_out_r  <= {DATA_WIDTH{1'b0}};
            r_valid_r   <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wptr_r      <= wptr_nxt_s;
            rptr_r      <= rptr_nxt_s;
            count_r     <= count_nxt_s;
            r_valid_r   <= rd_acc_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
            if (rd_acc_s) begin
                data_out_r <= mem_r[rptr_r];
            end
        end
    end

    // Storage array is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r] <= data_in;
        end
    end

    assign data_out     = data_out_r;
    assign r_valid      = r_valid_r;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = almost_full_s;
    assign almost_empty = almost_empty_s;
    assign count        = count_r;
    assign wptr         = wptr_r;
    assign rptr         = rptr_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    sync_fifo_param_chk #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .wptr  (wptr_r),
        .rptr  (rptr_r),
        .count (count_r),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// Structural invariants of the FIFO state, kept apart from the datapath.
module sync_fifo_param_chk #(
    parameter int DEPTH = 46,
    parameter int PTR_W = 6,
    parameter int CNT_W = 6
) (
    input logic             clk,
    input logic             rst_n,
    input logic [PTR_W-1:0] wptr,
    input logic [PTR_W-1:0] rptr,
    input logic [CNT_W-1:0] count,
    input logic             full,
    input logic             empty
);

    a_wptr_range: assert property (@(posedge clk) disable iff (!rst_n) int'(wptr) < DEPTH);
    a_rptr_range: assert property (@(posedge clk) disable iff (!rst_n) int'(rptr) < DEPTH);
    a_count_max:  assert property (@(posedge clk) disable iff (!rst_n) int'(count) <= DEPTH);
    a_flags_excl: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: default-parameter instance plus a small
// DEPTH=5 instance; read data is checked by a scoreboard monitor.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       w_en_a = 1'b0, r_en_a = 1'b0, flush_a = 1'b0, clr_err_a = 1'b0;
    logic [7:0] data_in_a = 8'h00, data_out_a;
    logic       r_valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [5:0] count_a, wptr_a, rptr_a;

    // Instance B: DEPTH=5, AF_TH=4, AE_TH=1, DATA_WIDTH=32
    logic        w_en_b = 1'b0, r_en_b = 1'b0;
    logic [31:0] data_in_b = 32'h0, data_out_b;
    logic        r_valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [2:0]  count_b, wptr_b, rptr_b;

    sync_fifo_param u_dut_a (
        .clk(clk), .rst_n(rst_n), .w_en(w_en_a), .data_in(data_in_a), .r_en(r_en_a),
        .flush(flush_a), .clr_err(clr_err_a), .data_out(data_out_a), .r_valid(r_valid_a),
        .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .count(count_a), .wptr(wptr_a), .rptr(rptr_a), .overflow(ovf_a), .underflow(unf_a)
    );

    sync_fifo_param #(.DATA_WIDTH(32), .DEPTH(5), .AF_TH(4), .AE_TH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .w_en(w_en_b), .data_in(data_in_b), .r_en(r_en_b),
        .flush(1'b0), .clr_err(1'b0), .data_out(data_out_b), .r_valid(r_valid_b),
        .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .count(count_b), .wptr(wptr_b), .rptr(rptr_b), .overflow(ovf_b), .underflow(unf_b)
    );

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0]  mq_a[$];
    logic [7:0]  sb_a[$];
    logic [31:0] mq_b[$];
    logic [31:0] sb_b[$];
    int wp_b = 0;
    int rp_b = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read-data monitor: pops the expected word whenever a DUT flags valid data
    always @(negedge clk) begin
        if (rst_n === 1'b1 && r_valid_a === 1'b1) begin
            if (sb_a.size() == 0) check("a_unexpected_rvalid", 64'd1, 64'd0);
            else check("a_rdata", {56'h0, data_out_a}, {56'h0, sb_a.pop_front()});
        end
        if (rst_n === 1'b1 && r_valid_b === 1'b1) begin
            if (sb_b.size() == 0) check("b_unexpected_rvalid", 64'd1, 64'd0);
            else check("b_rdata", {32'h0, data_out_b}, {32'h0, sb_b.pop_front()});
        end
    end

    task automatic step_a(input logic w, input logic [7:0] d, input logic r,
                          input logic fl, input logic ce);
        logic rd, wr;
        w_en_a = w; data_in_a = d; r_en_a = r; flush_a = fl; clr_err_a = ce;
        if (fl) begin
            mq_a.delete();
        end else begin
            rd = r && (mq_a.size() > 0);
            wr = w && (mq_a.size() < 46 || rd);
            if (rd) sb_a.push_back(mq_a.pop_front());
            if (wr) mq_a.push_back(d);
        end
        @(posedge clk); #1;
        w_en_a = 1'b0; r_en_a = 1'b0; flush_a = 1'b0; clr_err_a = 1'b0;
    endtask

    task automatic step_b(input logic w, input logic [31:0] d, input logic r);
        logic rd, wr;
        w_en_b = w; data_in_b = d; r_en_b = r;
        rd = r && (mq_b.size() > 0);
        wr = w && (mq_b.size() < 5 || rd);
        if (rd) begin
            sb_b.push_back(mq_b.pop_front());
            rp_b = (rp_b + 1) % 5;
        end
        if (wr) begin
            mq_b.push_back(d);
            wp_b = (wp_b + 1) % 5;
        end
        @(posedge clk); #1;
        w_en_b = 1'b0; r_en_b = 1'b0;
    endtask

    // {w_en, r_en} per operation for instance B
    logic [1:0] ops_b [20] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01,
                               2'b01, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10,
                               2'b11, 2'b01, 2'b10, 2'b01};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", {58'h0, count_a}, 64'd0);
        check("rst_empty", {63'h0, empty_a}, 64'd1);
        check("rst_ae", {63'h0, ae_a}, 64'd1);
        check("rst_full", {63'h0, full_a}, 64'd0);
        check("rst_af", {63'h0, af_a}, 64'd0);
        check("rst_ptrs", {52'h0, wptr_a, rptr_a}, 64'd0);
        check("rst_dout", {56'h0, data_out_a}, 64'd0);
        check("rst_rvalid_err", {61'h0, r_valid_a, ovf_a, unf_a}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full
        for (int i = 0; i < 46; i++) begin
            step_a(1'b1, 8'(i * 3 + 1), 1'b0, 1'b0, 1'b0);
            check("fill_count", {58'h0, count_a}, 64'(i + 1));
            if (i + 1 == 2)  check("fill_ae_at2", {63'h0, ae_a}, 64'd1);
            if (i + 1 == 3)  check("fill_ae_at3", {63'h0, ae_a}, 64'd0);
            if (i + 1 == 43) check("fill_af_at43", {63'h0, af_a}, 64'd0);
            if (i + 1 == 44) check("fill_af_at44", {63'h0, af_a}, 64'd1);
            if (i + 1 == 45) check("fill_wptr45", {58'h0, wptr_a}, 64'd45);
        end
        check("full_flag", {63'h0, full_a}, 64'd1);
        check("full_wptr_wrap", {58'h0, wptr_a}, 64'd0);

        step_a(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("ovf_set", {63'h0, ovf_a}, 64'd1);
        check("ovf_count", {58'h0, count_a}, 64'd46);
        check("ovf_wptr", {58'h0, wptr_a}, 64'd0);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", {63'h0, ovf_a}, 64'd0);

        // Full with simultaneous write and read
        step_a(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        check("fullrw_count", {58'h0, count_a}, 64'd46);
        check("fullrw_full", {63'h0, full_a}, 64'd1);
        check("fullrw_ovf", {63'h0, ovf_a}, 64'd0);
        check("fullrw_ptrs", {52'h0, wptr_a, rptr_a}, {52'h0, 6'd1, 6'd1});

        // Drain
        for (int i = 0; i < 46; i++) begin
            step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("drain_rvalid", {63'h0, r_valid_a}, 64'd1);
        end
        check("drain_empty", {63'h0, empty_a}, 64'd1);
        check("drain_count", {58'h0, count_a}, 64'd0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("unf_set", {63'h0, unf_a}, 64'd1);
        check("unf_rptr", {58'h0, rptr_a}, 64'd1);
        check("unf_rvalid", {63'h0, r_valid_a}, 64'd0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("unf_set_beats_clr", {63'h0, unf_a}, 64'd1);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("unf_clr", {63'h0, unf_a}, 64'd0);

        // Empty with simultaneous write and read: no bypass
        step_a(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
        check("emptyrw_count", {58'h0, count_a}, 64'd1);
        check("emptyrw_rvalid", {63'h0, r_valid_a}, 64'd0);
        check("emptyrw_unf", {63'h0, unf_a}, 64'd1);
        check("emptyrw_ptrs", {52'h0, wptr_a, rptr_a}, {52'h0, 6'd2, 6'd1});

        // Flush at count 10 with a write pending
        for (int i = 0; i < 9; i++) step_a(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
        check("preflush_count", {58'h0, count_a}, 64'd10);
        step_a(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        check("flush_count", {58'h0, count_a}, 64'd0);
        check("flush_empty", {63'h0, empty_a}, 64'd1);
        check("flush_ptrs", {52'h0, wptr_a, rptr_a}, 64'd0);
        check("flush_dout", {56'h0, data_out_a}, 64'hAA);
        check("flush_rvalid", {63'h0, r_valid_a}, 64'd0);
        check("flush_err_hold", {62'h0, ovf_a, unf_a}, 64'd1);
        step_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("flush_clr", {62'h0, ovf_a, unf_a}, 64'd0);
        step_a(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
        check("flush_noerr", {62'h0, ovf_a, unf_a}, 64'd0);
        check("flush_nowrite", {58'h0, count_a}, 64'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step_a(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", {58'h0, count_a}, 64'd0);
        check("arst_wptr", {58'h0, wptr_a}, 64'd0);
        check("arst_empty", {63'h0, empty_a}, 64'd1);
        mq_a.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step_a(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        check("post_rst_wptr", {58'h0, wptr_a}, 64'd1);
        step_a(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Alternate-parameter instance
        for (int i = 0; i < 20; i++) begin
            step_b(ops_b[i][1], 32'hC0DE_0000 + 32'(i), ops_b[i][0]);
            check("b_count", {61'h0, count_b}, 64'(mq_b.size()));
            check("b_flags", {60'h0, full_b, empty_b, af_b, ae_b},
                  {60'h0, mq_b.size() == 5, mq_b.size() == 0, mq_b.size() >= 4, mq_b.size() <= 1});
            check("b_ptrs", {58'h0, wptr_b, rptr_b}, {58'h0, 3'(wp_b), 3'(rp_b)});
        end
        check("b_err_flags", {62'h0, ovf_b, unf_b}, 64'd3);

        for (int i = 0; i < 5 && (sb_a.size() != 0 || sb_b.size() != 0); i++) @(posedge clk);
        #1;
        check("sb_a_drained", 64'(sb_a.size()), 64'd0);
        check("sb_b_drained", 64'(sb_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
